// File: rtl/apb_uart_pkg.sv
// Register map, bit positions and CTRL layout shared by the UART APB register interface.
package apb_uart_pkg;

  localparam logic [4:0] OFF_TXDATA = 5'h00;
  localparam logic [4:0] OFF_RXDATA = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_IRQ    = 5'h10;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int IRQ_TX_LOW  = 0;
  localparam int IRQ_RX_HIGH = 1;
  localparam int IRQ_OVERRUN = 2;

  localparam int CTRL_W = 19;

  typedef struct packed {
    logic       ovr_ie;
    logic       rx_ie;
    logic       tx_ie;
    logic [7:0] rx_thresh;
    logic [7:0] tx_thresh;
  } ctrl_t;

endpackage

// File: rtl/apb_uart_regif_if.sv
// APB3 bus bundle between the fabric (master) and the UART register block (slave).
interface apb_uart_regif_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/dti_fifo_sync.sv
// Single-clock first-word-fall-through FIFO; push is ignored when full, pop when empty.
module dti_fifo_sync #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 32,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a same-edge pop never makes room for a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/apb_uart_regif.sv
// APB slave register map for the UART: TX/RX FIFOs, status, thresholds, sticky overrun and IRQ.
module apb_uart_regif
  import apb_uart_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TX_DEPTH       = 32,
  parameter int RX_DEPTH       = 32,
  parameter int WAIT_STATES    = 1
) (
  input  logic                  apb_pclk,
  input  logic                  apb_preset,
  apb_uart_regif_if.slave       apb,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  irq
);

  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  logic [1:0]            wait_q, wait_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic                  overrun_q, overrun_d;
  logic                  irq_q, irq_d;

  logic                  access, pready, xfer;
  logic [4:0]            off;
  logic [APB_DATA_WIDTH-1:0] rdata, status_w;
  logic                  err;
  logic                  tx_push, rx_pop, ctrl_we, ovr_clr, ovr_set;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0]      tx_count;
  logic [RX_CW-1:0]      rx_count;
  logic [7:0]            tx_cnt8, rx_cnt8;
  logic [DATA_WIDTH-1:0] rx_dout;
  logic [2:0]            irq_stat;
  logic                  unused_bits;

  dti_fifo_sync #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (apb_pclk),
    .rst_i   (apb_preset),
    .push_i  (tx_push),
    .pop_i   (tx_valid & tx_ready),
    .din_i   (apb.pwdata[DATA_WIDTH-1:0]),
    .dout_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  dti_fifo_sync #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (apb_pclk),
    .rst_i   (apb_preset),
    .push_i  (rx_valid),
    .pop_i   (rx_pop),
    .din_i   (rx_data),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign tx_valid = ~tx_empty;
  assign tx_cnt8  = 8'(tx_count);
  assign rx_cnt8  = 8'(rx_count);
  assign ovr_set  = rx_valid & rx_full;

  // pready is combinational in access cycle WAIT_STATES; the counter restarts after each transfer.
  assign access = apb.psel & apb.penable;
  assign pready = access & (wait_q == 2'(WAIT_STATES));
  assign xfer   = pready;
  assign wait_d = (!access || pready) ? 2'd0 : wait_q + 2'd1;

  assign off = {apb.paddr[4:2], 2'b00};

  always_comb begin
    irq_stat              = '0;
    irq_stat[IRQ_TX_LOW]  = (tx_cnt8 <= ctrl_q.tx_thresh);
    irq_stat[IRQ_RX_HIGH] = (rx_cnt8 >= ctrl_q.rx_thresh) && (rx_cnt8 != 8'd0);
    irq_stat[IRQ_OVERRUN] = overrun_q;

    status_w                                = '0;
    status_w[ST_TX_EMPTY]                   = tx_empty;
    status_w[ST_TX_FULL]                    = tx_full;
    status_w[ST_RX_EMPTY]                   = rx_empty;
    status_w[ST_RX_FULL]                    = rx_full;
    status_w[ST_OVERRUN]                    = overrun_q;
    status_w[ST_TX_CNT_LSB +: 8]            = tx_cnt8;
    status_w[ST_RX_CNT_LSB +: 8]            = rx_cnt8;
  end

  always_comb begin
    rdata   = '0;
    err     = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    ctrl_we = 1'b0;
    ovr_clr = 1'b0;
    case (off)
      OFF_TXDATA: if (apb.pwrite) begin
        if (tx_full) err = 1'b1;
        else         tx_push = xfer;
      end
      OFF_RXDATA: if (!apb.pwrite) begin
        if (rx_empty) err = 1'b1;
        else begin
          rdata[DATA_WIDTH-1:0] = rx_dout;
          rx_pop                = xfer;
        end
      end
      OFF_STATUS: if (!apb.pwrite) rdata = status_w;
      OFF_CTRL: begin
        if (apb.pwrite) ctrl_we = xfer;
        else            rdata[CTRL_W-1:0] = ctrl_q;
      end
      OFF_IRQ: begin
        if (apb.pwrite) ovr_clr = xfer & apb.pwdata[IRQ_OVERRUN];
        else            rdata[2:0] = irq_stat;
      end
      default: err = 1'b1;
    endcase
  end

  assign apb.pready  = pready;
  assign apb.prdata  = xfer ? rdata : '0;
  assign apb.pslverr = xfer & err;

  // A new overrun on the same edge as the W1C keeps the flag set.
  assign overrun_d = ovr_set | (overrun_q & ~ovr_clr);
  assign ctrl_d    = ctrl_we ? ctrl_t'(apb.pwdata[CTRL_W-1:0]) : ctrl_q;
  assign irq_d     = |(irq_stat & {ctrl_q.ovr_ie, ctrl_q.rx_ie, ctrl_q.tx_ie});
  assign irq       = irq_q;

  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      wait_q    <= '0;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      ctrl_q    <= ctrl_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign unused_bits = ^{apb.paddr[APB_ADDR_WIDTH-1:5], apb.paddr[1:0],
                         apb.pwdata[APB_DATA_WIDTH-1:CTRL_W]};

endmodule

// File: tb/tb_apb_uart_regif.sv
// Directed bench for apb_uart_regif: reset, TX/RX FIFO paths, overrun/IRQ, thresholds, bad address.
module tb_apb_uart_regif;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       irq;

  int asserts = 0;
  int fails   = 0;

  apb_uart_regif_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  apb_uart_regif #(
    .APB_ADDR_WIDTH(12), .APB_DATA_WIDTH(32), .DATA_WIDTH(8),
    .TX_DEPTH(32), .RX_DEPTH(32), .WAIT_STATES(1)
  ) dut (
    .apb_pclk  (clk),
    .apb_preset(rst),
    .apb       (bus),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Setup cycle, then access cycles until pready; returns access-cycle index of pready.
  task automatic apb_xfer(input logic [11:0] a, input logic w, input logic [31:0] wd,
                          input logic pulse_txr, output logic [31:0] rd,
                          output logic err, output int waits);
    int n;
    bit done;
    @(posedge clk); #1;
    bus.paddr = a; bus.pwrite = w; bus.pwdata = wd; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    n = 0; done = 0; rd = '0; err = 1'b1;
    while (!done && n < 8) begin
      #3;
      if (bus.pready === 1'b1) begin
        rd = bus.prdata; err = bus.pslverr; done = 1;
        if (pulse_txr) tx_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) n++;
    end
    tx_ready = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    waits = n;
    if (!done) begin
      asserts++; fails++;
      $display("FAIL apb_timeout: addr %h no pready within %0d cycles", a, n);
    end
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int w;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    asserts++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL reset_pready: got %b want 0", bus.pready); end
    asserts++; if (bus.prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata: got %h want 0", bus.prdata); end
    asserts++; if (bus.pslverr !== 1'b0) begin fails++; $display("FAIL reset_pslverr: got %b want 0", bus.pslverr); end
    asserts++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    asserts++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    apb_xfer(12'h008, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h5 || err !== 1'b0) begin fails++; $display("FAIL reset_status: got %h err %b want 00000005 err 0", rd, err); end
  endtask

  task automatic test_tx_push_drain();
    logic [31:0] rd; logic err; int w;
    apb_xfer(12'h000, 1'b1, 32'h41, 1'b0, rd, err, w);
    asserts++; if (w !== 1) begin fails++; $display("FAIL tx_wait_states: pready at access cycle %0d want 1", w); end
    asserts++; if (err !== 1'b0) begin fails++; $display("FAIL tx_push_err: got %b want 0", err); end
    asserts++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL tx_head: valid %b data %h want 1 41", tx_valid, tx_data); end
    tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    asserts++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_drained: valid %b want 0", tx_valid); end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd; logic err; int w;
    for (int i = 0; i < 32; i++) begin
      apb_xfer(12'h000, 1'b1, 32'(8'h10 + i), 1'b0, rd, err, w);
      asserts++; if (err !== 1'b0) begin fails++; $display("FAIL tx_fill_err: entry %0d err %b want 0", i, err); end
    end
    apb_xfer(12'h000, 1'b1, 32'hFF, 1'b0, rd, err, w);
    asserts++; if (err !== 1'b1) begin fails++; $display("FAIL tx_full_err: got %b want 1", err); end
    apb_xfer(12'h008, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0000_2006) begin fails++; $display("FAIL tx_full_status: got %h want 00002006", rd); end
    tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      asserts++; if (tx_data !== 8'(8'h10 + i)) begin fails++; $display("FAIL tx_order: entry %0d got %h want %h", i, tx_data, 8'(8'h10 + i)); end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    asserts++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_full_drain: valid %b want 0", tx_valid); end
  endtask

  task automatic test_rx_read_empty();
    logic [31:0] rd; logic err; int w;
    rx_push(8'h5A);
    apb_xfer(12'h004, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h5A || err !== 1'b0) begin fails++; $display("FAIL rx_read: got %h err %b want 0000005a err 0", rd, err); end
    apb_xfer(12'h004, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0 || err !== 1'b1) begin fails++; $display("FAIL rx_empty_read: got %h err %b want 0 err 1", rd, err); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] rd; logic err; int w;
    apb_xfer(12'h00C, 1'b1, 32'h0004_0000, 1'b0, rd, err, w);
    for (int i = 0; i < 32; i++) rx_push(8'(i + 1));
    rx_push(8'hEE);
    asserts++; if (irq !== 1'b0) begin fails++; $display("FAIL ovr_irq_lag: got %b want 0", irq); end
    @(posedge clk); #1;
    asserts++; if (irq !== 1'b1) begin fails++; $display("FAIL ovr_irq_set: got %b want 1", irq); end
    apb_xfer(12'h008, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0020_0019) begin fails++; $display("FAIL ovr_status: got %h want 00200019", rd); end
    apb_xfer(12'h010, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h7) begin fails++; $display("FAIL ovr_irqstat: got %h want 00000007", rd); end
    apb_xfer(12'h010, 1'b1, 32'h4, 1'b0, rd, err, w);
    asserts++; if (irq !== 1'b1) begin fails++; $display("FAIL ovr_clr_lag: irq %b want 1", irq); end
    @(posedge clk); #1;
    asserts++; if (irq !== 1'b0) begin fails++; $display("FAIL ovr_clr_irq: irq %b want 0", irq); end
    apb_xfer(12'h010, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h3) begin fails++; $display("FAIL ovr_clr_irqstat: got %h want 00000003", rd); end
    for (int i = 0; i < 32; i++) begin
      apb_xfer(12'h004, 1'b0, 32'h0, 1'b0, rd, err, w);
      asserts++; if (rd !== 32'(i + 1) || err !== 1'b0) begin fails++; $display("FAIL rx_order: entry %0d got %h err %b want %h err 0", i, rd, err, i + 1); end
    end
    apb_xfer(12'h008, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h5) begin fails++; $display("FAIL rx_drained_status: got %h want 00000005", rd); end
  endtask

  task automatic test_threshold_badaddr();
    logic [31:0] rd; logic err; int w;
    apb_xfer(12'h00C, 1'b1, 32'h0002_0300, 1'b0, rd, err, w);
    rx_push(8'hA1);
    rx_push(8'hA2);
    @(posedge clk); #1;
    asserts++; if (irq !== 1'b0) begin fails++; $display("FAIL thr_below: irq %b want 0", irq); end
    rx_push(8'hA3);
    @(posedge clk); #1;
    asserts++; if (irq !== 1'b1) begin fails++; $display("FAIL thr_reached: irq %b want 1", irq); end
    apb_xfer(12'h014, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0 || err !== 1'b1) begin fails++; $display("FAIL bad_read: got %h err %b want 0 err 1", rd, err); end
    apb_xfer(12'h014, 1'b1, 32'hFFFF_FFFF, 1'b0, rd, err, w);
    asserts++; if (err !== 1'b1) begin fails++; $display("FAIL bad_write: err %b want 1", err); end
    apb_xfer(12'h01C, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (err !== 1'b1) begin fails++; $display("FAIL bad_read_1c: err %b want 1", err); end
    apb_xfer(12'h004, 1'b1, 32'hFF, 1'b0, rd, err, w);
    asserts++; if (err !== 1'b0) begin fails++; $display("FAIL rxdata_write: err %b want 0", err); end
    apb_xfer(12'h000, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL txdata_read: got %h err %b want 0 err 0", rd, err); end
    apb_xfer(12'h00C, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0002_0300) begin fails++; $display("FAIL ctrl_readback: got %h want 00020300", rd); end
    apb_xfer(12'h008, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0003_0001) begin fails++; $display("FAIL thr_status: got %h want 00030001", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w;
    for (int i = 0; i < 32; i++) apb_xfer(12'h000, 1'b1, 32'(8'h30 + i), 1'b0, rd, err, w);
    // tx_ready pops on the same edge as a push into the full FIFO: push still rejected
    apb_xfer(12'h000, 1'b1, 32'hAB, 1'b1, rd, err, w);
    asserts++; if (err !== 1'b1) begin fails++; $display("FAIL b2b_full_push: err %b want 1", err); end
    asserts++; if (tx_data !== 8'h31) begin fails++; $display("FAIL b2b_head: got %h want 31", tx_data); end
    apb_xfer(12'h008, 1'b0, 32'h0, 1'b0, rd, err, w);
    asserts++; if (rd !== 32'h0003_1F00) begin fails++; $display("FAIL b2b_status: got %h want 00031f00", rd); end
    tx_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      asserts++; if (tx_data !== 8'(8'h31 + i)) begin fails++; $display("FAIL b2b_order: entry %0d got %h want %h", i, tx_data, 8'(8'h31 + i)); end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    asserts++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: valid %b want 0", tx_valid); end
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    bus.paddr = '0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.pwdata = '0;
    test_reset();
    test_tx_push_drain();
    test_tx_full();
    test_rx_read_empty();
    test_rx_overrun();
    test_threshold_badaddr();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
